sum_of_squares: RTL and testbench

SUM_OF_SQUARES -- requirements
Module: sum_of_squares

---
 rtl/sqrt_pkg.sv | 9 +
 rtl/seq_mult.sv | 45 ++++
 rtl/sum_of_squares.sv | 62 ++++++
 tb/tb_sum_of_squares.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared FSM state type and operand-width derivation for the
// sum-of-squares front end of the square-root stage.
package sqrt_pkg;
   typedef enum logic [1:0] {IDLE, MUL_A, MUL_B, ISSUE} state_t;
   // Operand width for a given radicand width; keeps 2*(2^opw-1)^2 inside width bits.
   function automatic int opw_of(input int width);
      return width / 2 - 1;
   endfunction
endpackage

// File: rtl/seq_mult.sv
// seq_mult: iterative shift-add multiply-accumulate, one multiplier bit per step.
// Ports: clk, rst_n (async active-low); clear zeroes the accumulator; load
// captures op as both multiplicand and multiplier and restarts the bit counter;
// step adds one partial product; acc is the running sum; done flags the last bit.
module seq_mult #(
   parameter int WIDTH = 16,
   parameter int OPW   = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             load,
   input  logic             step,
   input  logic [OPW-1:0]   op,
   output logic [WIDTH-1:0] acc,
   output logic             done
);
   localparam int CW = $clog2(OPW + 1);
   logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
   logic [OPW-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   // load and step may coincide on the last bit of the first operand: the final
   // partial product is still added while the next operand is captured.
   always_comb begin
      acc_d    = clear ? '0 : (step && mplier_q[0]) ? acc_q + mcand_q : acc_q;
      mcand_d  = load ? WIDTH'(op) : step ? mcand_q << 1 : mcand_q;
      mplier_d = load ? op : step ? mplier_q >> 1 : mplier_q;
      cnt_d    = load ? '0 : step ? cnt_q + CW'(1) : cnt_q;
      done     = cnt_q == CW'(OPW - 1);
      acc      = acc_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: rtl/sum_of_squares.sv
// sum_of_squares: computes a*a+b*b serially and hands it to a square-root stage.
// Ports: clk, rst_n (async active-low); in_valid/in_ready operand handshake with
// unsigned a, b; sqrt_busy from the root stage; start is a one-cycle issue pulse
// with the radicand on rad, which holds until the next start.
module sum_of_squares
   import sqrt_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH/2-2:0] a,
   input  logic [WIDTH/2-2:0] b,
   input  logic               sqrt_busy,
   output logic               start,
   output logic [WIDTH-1:0]   rad
);
   localparam int OPW = opw_of(WIDTH);
   state_t           state_q, state_d;
   logic             in_ready_q, in_ready_d, start_q;
   logic [OPW-1:0]   b_q, b_d, op;
   logic [WIDTH-1:0] rad_q, acc;
   logic             accept, load, step, done;
   seq_mult #(.WIDTH(WIDTH), .OPW(OPW)) u_mult (
      .clk(clk), .rst_n(rst_n), .clear(accept), .load(load), .step(step),
      .op(op), .acc(acc), .done(done)
   );
   // start is combinational on sqrt_busy; start_q blocks a second pulse in the
   // cycle before the root stage's busy flag has had a chance to rise.
   always_comb begin
      accept     = in_ready_q && in_valid;
      start      = state_q == ISSUE && !sqrt_busy && !start_q;
      step       = state_q == MUL_A || state_q == MUL_B;
      load       = accept || (state_q == MUL_A && done);
      op         = accept ? a : b_q;
      b_d        = accept ? b : b_q;
      state_d    = accept ? MUL_A :
                   (state_q == MUL_A && done) ? MUL_B :
                   (state_q == MUL_B && done) ? ISSUE :
                   start ? IDLE : state_q;
      in_ready_d = accept ? 1'b0 : (state_q == IDLE || start) ? 1'b1 : in_ready_q;
      rad        = start ? acc : rad_q;
      in_ready   = in_ready_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         in_ready_q <= 1'b0;
         start_q    <= 1'b0;
         b_q        <= '0;
         rad_q      <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         start_q    <= start;
         b_q        <= b_d;
         rad_q      <= rad;
      end
   end
endmodule

// File: tb/tb_sum_of_squares.sv
// tb_sum_of_squares: scoreboard bench for sum_of_squares with directed operand pairs.
module tb_sum_of_squares;
   localparam int WIDTH = 16;
   localparam int OPW   = WIDTH / 2 - 1;
   typedef struct {int r; int lat;} exp_t;
   logic             clk = 0, rst_n = 0, in_valid = 0, busy_force = 0;
   logic [OPW-1:0]   a_i = '0, b_i = '0;
   logic             in_ready, sqrt_busy, start;
   logic [WIDTH-1:0] rad;
   exp_t exp_q[$];
   int   acc_q[$];
   int   errors = 0, checks = 0, cyc = 0, bcnt = 0, held = 0;
   bit   pstart = 0, chk_rdy = 0;

   sum_of_squares #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a_i), .b(b_i), .sqrt_busy(sqrt_busy), .start(start), .rad(rad)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // Root-stage model: busy rises one edge after start and lasts three cycles.
   always @(posedge clk) bcnt <= start ? 3 : (bcnt > 0 ? bcnt - 1 : 0);
   assign sqrt_busy = busy_force | (bcnt != 0);

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: records accepts, pops the scoreboard on every start pulse.
   always @(negedge clk) begin : mon
      exp_t e;
      int t;
      if (!rst_n) begin
         held = 0;
         acc_q.delete();
         pstart = 0;
         chk_rdy = 0;
      end else begin
         if (chk_rdy) chk("ready_after_start", int'(in_ready), 1);
         chk_rdy = 0;
         if (in_valid && in_ready) acc_q.push_back(cyc);
         if (start) begin
            chk("start_gap", int'(pstart), 0);
            chk("ready_in_start", int'(in_ready), 0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_start: rad=%0d with no pair pending", rad);
            end else begin
               e = exp_q.pop_front();
               chk("rad", int'(rad), e.r);
               if (acc_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL latency: start with no recorded accept, required %0d", e.lat);
               end else begin
                  t = acc_q.pop_front();
                  chk("latency", cyc - t, e.lat);
               end
            end
            held = int'(rad);
            chk_rdy = 1;
         end else chk("rad_hold", int'(rad), held);
         pstart = start;
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: in_ready=%0d required 1", in_ready);
      end
   endtask

   task automatic send(input int av, input int bv, input int r, input int lat, input bit pend);
      wait_ready();
      a_i = OPW'(av);
      b_i = OPW'(bv);
      in_valid = 1;
      if (pend) exp_q.push_back('{r, lat});
      @(posedge clk); #1;
      in_valid = 0;
      a_i = '1;
      b_i = '1;
   endtask

   task automatic junk(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1;
         a_i = '1;
         b_i = '1;
         @(posedge clk); #1;
         chk("ready_while_busy", int'(in_ready), 0);
      end
      in_valid = 0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: pending=%0d required 0", exp_q.size());
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      chk("reset_ready", int'(in_ready), 0);
      chk("reset_start", int'(start), 0);
      chk("reset_rad", int'(rad), 0);
      @(posedge clk); #1;
      rst_n = 1;
      chk("ready_before_edge", int'(in_ready), 0);
      @(posedge clk); #1;
      chk("ready_after_reset", int'(in_ready), 1);

      send(3, 4, 25, 15, 1);
      junk(3);
      drain();
      send(127, 127, 32258, 15, 1);
      drain();
      send(0, 0, 0, 15, 1);
      drain();

      busy_force = 1;
      send(5, 12, 169, 20, 1);
      repeat (19) begin
         @(posedge clk); #1;
         chk("ready_busy_wait", int'(in_ready), 0);
      end
      busy_force = 0;
      drain();

      send(1, 1, 2, 15, 1);
      send(2, 2, 8, 15, 1);
      drain();

      send(7, 7, 98, 15, 0);
      repeat (9) @(posedge clk);
      #1;
      rst_n = 0;
      #1;
      chk("midreset_start", int'(start), 0);
      chk("midreset_rad", int'(rad), 0);
      chk("midreset_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      rst_n = 1;
      chk("release_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      chk("release_ready_edge", int'(in_ready), 1);
      repeat (25) @(posedge clk);
      #1;

      send(6, 8, 100, 15, 1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
